// File: rtl/ay_bus_master.sv
// Purpose : sequences host register reads/writes onto a PSG-style BDIR/BC/DO/DI bus.
// Latency : 4 CE steps per transaction, 6 when a chip-select phase is needed.
// Backpress: REQ_READY only in IDLE; requests presented while BUSY are ignored.
//
// Ports:
//   CLK, RESET_L (async active-low), CE (bus step enable shared with the PSGs)
//   REQ_VALID/REQ_READY/REQ_RD/REQ_CHIP/REQ_ADDR/REQ_DATA : host request
//   RSP_VALID/RSP_DATA : read response (pulse / held data)
//   BDIR/BC/DO/DI : PSG bus, BUSY : transaction in progress
//
// Build option: define AY_BUS_MASTER_TURBO_EN to enable dual-chip selection
// (SEL/GAP1 phases and the cur_chip tracker). Without it REQ_CHIP is ignored.

module ay_bus_master (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       CE,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RD,
  input  logic       REQ_CHIP,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    GAP1 = 3'd2,
    ADDR = 3'd3,
    GAP2 = 3'd4,
    XFER = 3'd5,
    GAP3 = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       want_sel;
  logic [7:0] first_do;
  logic       bdir_c;
  logic       bc_c;

  // Captured request fields, valid for the whole transaction.
  logic       rd_q;
  logic [3:0] addr_q;
  logic [7:0] data_q;

  // READY is gated by RESET_L so the host never sees it while reset is held.
  assign REQ_READY = (state == IDLE) && RESET_L;
  assign accept    = REQ_VALID && REQ_READY;
  assign BUSY      = (state != IDLE);

`ifdef AY_BUS_MASTER_TURBO_EN
  // cur_chip mirrors which PSG currently listens; it resets to 1 because that
  // is the selection the PSG pair itself comes out of reset with.
  logic cur_chip;
  logic chip_q;

  assign want_sel = (REQ_CHIP != cur_chip);
  // Select pattern has an all-ones upper part, so it can never alias with an
  // address phase (upper nibble forced to zero).
  assign first_do = want_sel ? {7'h7F, REQ_CHIP} : {4'h0, REQ_ADDR};

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cur_chip <= 1'b1;
      chip_q   <= 1'b0;
    end else begin
      if (accept) begin
        chip_q <= REQ_CHIP;
      end
      if (CE && (state == SEL)) begin
        cur_chip <= chip_q;
      end
    end
  end
`else
  logic unused_chip;

  assign unused_chip = REQ_CHIP;
  assign want_sel    = 1'b0;
  assign first_do    = {4'h0, REQ_ADDR};
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and bus control. Leaving IDLE happens on the accept edge
  // regardless of CE; every other transition waits for a CE step.
  always_comb begin
    state_nxt = state;
    bdir_c    = 1'b0;
    bc_c      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = want_sel ? SEL : ADDR;
        end
      end
      SEL: begin
        bdir_c = 1'b1;
        bc_c   = 1'b1;
        if (CE) state_nxt = GAP1;
      end
      GAP1: begin
        if (CE) state_nxt = ADDR;
      end
      ADDR: begin
        bdir_c = 1'b1;
        bc_c   = 1'b1;
        if (CE) state_nxt = GAP2;
      end
      GAP2: begin
        if (CE) state_nxt = XFER;
      end
      XFER: begin
        // Write: BDIR=1/BC=0. Read: BDIR=0/BC=1 so the PSG drives DI.
        bdir_c = !rd_q;
        bc_c   = rd_q;
        if (CE) state_nxt = GAP3;
      end
      GAP3: begin
        if (CE) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign BDIR = bdir_c;
  assign BC   = bc_c;

  // Request capture; independent of CE so the host handshake is never stalled
  // by the bus clock enable.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      rd_q   <= 1'b0;
      addr_q <= 4'h0;
      data_q <= 8'h00;
    end else if (accept) begin
      rd_q   <= REQ_RD;
      addr_q <= REQ_ADDR;
      data_q <= REQ_DATA;
    end
  end

  // DO is loaded on entry to each driving phase and otherwise holds, so gaps
  // and IDLE keep presenting the last driven value. A read XFER leaves the
  // address on DO.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      DO <= 8'h00;
    end else if (accept) begin
      DO <= first_do;
    end else if (CE) begin
      case (state)
        GAP1: DO <= {4'h0, addr_q};
        GAP2: if (!rd_q) DO <= data_q;
        default: ;
      endcase
    end
  end

  // DI is sampled on the CE edge that leaves a read XFER; RSP_VALID is a
  // single-clock pulse after it, RSP_DATA holds until the next read.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
    end else begin
      RSP_VALID <= 1'b0;
      if (CE && (state == XFER) && rd_q) begin
        RSP_VALID <= 1'b1;
        RSP_DATA  <= DI;
      end
    end
  end

endmodule

// File: tb/tb_ay_bus_master.sv
// Scoreboard bench for ay_bus_master: a request-level model expands every
// accepted request into the list of bus phases it must produce; a monitor
// pops one phase per DUT step and checks outputs, including holds while CE=0.

module tb_ay_bus_master;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       CE;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_RD;
  logic       REQ_CHIP;
  logic [3:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BDIR;
  logic       BC;
  logic [7:0] DO;
  logic [7:0] DI;
  logic       BUSY;

  ay_bus_master dut (
    .CLK(CLK), .RESET_L(RESET_L), .CE(CE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RD(REQ_RD),
    .REQ_CHIP(REQ_CHIP), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .BDIR(BDIR), .BC(BC), .DO(DO), .DI(DI), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       bdir;
    logic       bc;
    logic       busy;
    logic       do_chk;
    logic       rsp;
    logic [7:0] dout;
  } phase_t;

  phase_t     exp_q[$];
  logic [7:0] rsp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       model_cur_chip = 1'b1;
  logic [7:0] model_last_do = 8'h00;
  logic       frozen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic phase_t mk(input logic bdir, input logic bc, input logic busy,
                                input logic do_chk, input logic rsp, input logic [7:0] dout);
    phase_t p;
    p.bdir = bdir; p.bc = bc; p.busy = busy; p.do_chk = do_chk; p.rsp = rsp; p.dout = dout;
    return p;
  endfunction

  function automatic void push_drive(input logic bdir, input logic bc, input logic [7:0] v);
    model_last_do = v;
    exp_q.push_back(mk(bdir, bc, 1'b1, 1'b1, 1'b0, v));
  endfunction

  // Expand one request into its bus phase list, ending with the IDLE return.
  function automatic void model_request(input logic rd, input logic chip, input logic [3:0] addr,
                                        input logic [7:0] data, input logic [7:0] di);
    logic sel;
`ifdef AY_BUS_MASTER_TURBO_EN
    sel = (chip != model_cur_chip);
`else
    sel = 1'b0 && (chip != model_cur_chip);
`endif
    if (sel) begin
      push_drive(1'b1, 1'b1, {7'h7F, chip});
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, model_last_do));
      model_cur_chip = chip;
    end
    push_drive(1'b1, 1'b1, {4'h0, addr});
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, model_last_do));
    if (rd) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
    else    push_drive(1'b1, 1'b0, data);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, rd, model_last_do));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, model_last_do));
    if (rd) rsp_q.push_back(di);
  endfunction

  // Monitor: samples 1 time unit after the falling edge.
  initial begin : monitor
    phase_t     cur;
    logic       trans;
    logic       popped;
    logic [7:0] last_rsp;
    cur      = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    trans    = 1'b0;
    last_rsp = 8'h00;
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET_L) begin
        check("rst_bdir", BDIR, 0);
        check("rst_bc", BC, 0);
        check("rst_do", DO, 8'h00);
        check("rst_busy", BUSY, 0);
        check("rst_ready", REQ_READY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_data", RSP_DATA, 8'h00);
        exp_q.delete();
        rsp_q.delete();
        cur      = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        trans    = 1'b0;
        last_rsp = 8'h00;
      end else begin
        popped = 1'b0;
        if (trans) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_bus_step: got BUSY=%0b BDIR=%0b BC=%0b expected no step", BUSY, BDIR, BC);
          end else begin
            cur    = exp_q.pop_front();
            popped = 1'b1;
          end
        end
        check("bdir", BDIR, cur.bdir);
        check("bc", BC, cur.bc);
        check("busy", BUSY, cur.busy);
        check("ready", REQ_READY, !cur.busy);
        if (cur.do_chk) check("do", DO, cur.dout);
        check("rsp_valid", RSP_VALID, popped && cur.rsp);
        if (popped && cur.rsp && rsp_q.size() != 0) last_rsp = rsp_q.pop_front();
        check("rsp_data", RSP_DATA, last_rsp);
        trans = (REQ_VALID && REQ_READY) || (CE && BUSY);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
    CE = frozen ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic garbage();
    REQ_RD   = 1'($urandom);
    REQ_CHIP = 1'($urandom);
    REQ_ADDR = 4'($urandom);
    REQ_DATA = 8'($urandom);
  endtask

  task automatic issue(input logic rd, input logic chip, input logic [3:0] addr,
                       input logic [7:0] data, input logic [7:0] di);
    for (int n = 0; n < 300 && !REQ_READY; n++) begin
      // Requests offered while busy must be ignored.
      REQ_VALID = ($urandom_range(0, 2) == 0);
      garbage();
      tick();
    end
    if (!REQ_READY) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got READY=0 expected READY=1");
      REQ_VALID = 1'b0;
    end else begin
      model_request(rd, chip, addr, data, di);
      REQ_VALID = 1'b1;
      REQ_RD    = rd;
      REQ_CHIP  = chip;
      REQ_ADDR  = addr;
      REQ_DATA  = data;
      DI        = di;
      tick();
      REQ_VALID = 1'b0;
      garbage();
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && BUSY; n++) tick();
    if (BUSY) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got BUSY=1 expected BUSY=0");
    end
  endtask

  task automatic assert_reset();
    RESET_L        = 1'b0;
    model_cur_chip = 1'b1;
    model_last_do  = 8'h00;
  endtask

  initial begin : driver
    CE        = 1'b0;
    REQ_VALID = 1'b0;
    DI        = 8'h00;
    garbage();
    assert_reset();
    repeat (3) tick();
    RESET_L = 1'b1;
    tick();

    // Chip 1 write right after reset: no select phase.
    issue(1'b0, 1'b1, 4'd7, 8'h38, 8'h00);
    wait_idle();
    // Chip 0 write: select phase in the dual-chip build; repeat without one.
    issue(1'b0, 1'b0, 4'd0, 8'h55, 8'h00);
    issue(1'b0, 1'b0, 4'd0, 8'h55, 8'h00);
    wait_idle();
    // Chip 0 read of register 14.
    issue(1'b1, 1'b0, 4'd14, 8'h00, 8'hA5);
    wait_idle();

    // Freeze the bus for 10 clocks in the address phase while poking REQ_VALID.
    issue(1'b0, 1'b0, 4'd3, 8'h12, 8'h00);
    frozen = 1'b1;
    CE     = 1'b0;
    repeat (10) begin
      REQ_VALID = 1'b1;
      garbage();
      tick();
    end
    REQ_VALID = 1'b0;
    check("freeze_addr_phase", {BDIR, BC, DO}, {1'b1, 1'b1, 8'h03});
    frozen = 1'b0;
    wait_idle();

    // Reset in the middle of a read transfer.
    issue(1'b1, 1'b0, 4'd9, 8'h00, 8'h3C);
    for (int n = 0; n < 200 && !(BUSY && !BDIR && BC); n++) tick();
    check("reached_read_xfer", {BUSY, BDIR, BC}, 3'b101);
    #3;
    assert_reset();
    #1;
    check("async_rst_bdir", BDIR, 0);
    check("async_rst_bc", BC, 0);
    check("async_rst_busy", BUSY, 0);
    repeat (3) tick();
    RESET_L = 1'b1;
    tick();
    // Chip 1 after reset: no select phase.
    issue(1'b0, 1'b1, 4'd2, 8'hC3, 8'h00);
    wait_idle();

    // Randomised traffic, mostly back-to-back.
    for (int t = 0; t < 40; t++) begin
      issue(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_idle();
    repeat (5) tick();
    check("phases_drained", exp_q.size(), 0);
    check("responses_drained", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
